// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns LB/LH/LW(U) and SB/SH/SW into byte-serial RAM
// transfers and presents load results / pass-through ALU results on registered write-back outputs.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [3:0]  mem_op,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_we,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    output logic        ram_req,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    input  logic        ram_ack,
    output logic [4:0]  wb_waddr,
    output logic        wb_we,
    output logic [31:0] wb_wdata,
    output logic        stall_req
);

    localparam int unsigned XW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 2;

    localparam logic [OW-1:0] OP_LB  = OW'(1);
    localparam logic [OW-1:0] OP_LH  = OW'(2);
    localparam logic [OW-1:0] OP_LBU = OW'(4);
    localparam logic [OW-1:0] OP_LHU = OW'(5);
    localparam logic [OW-1:0] OP_SB  = OW'(6);
    localparam logic [OW-1:0] OP_SH  = OW'(7);
    localparam logic [OW-1:0] OP_SW  = OW'(8);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, last_q, last_d;
    logic [OW-1:0] op_q, op_d;
    logic [XW-1:0] addr_q, addr_d, sdata_q, sdata_d, lbuf_q, lbuf_d;
    logic [RW-1:0] waddr_q, waddr_d, wb_waddr_d;
    logic          we_q, we_d, wb_we_d;
    logic [XW-1:0] wb_wdata_d;

    logic          in_ls, store_q;
    logic [CW-1:0] in_last;
    logic [4:0]    bsel;
    logic [XW-1:0] raw, ext;

    // Decode of the incoming op and of the latched op.
    always_comb begin
        in_ls   = (mem_op >= OP_LB) && (mem_op <= OP_SW);
        store_q = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
        case (mem_op)
            OP_LB, OP_LBU, OP_SB: in_last = CW'(0);
            OP_LH, OP_LHU, OP_SH: in_last = CW'(1);
            default:              in_last = CW'(3);
        endcase
    end

    // Load assembly: buffered bytes plus the byte arriving this cycle, then extension.
    always_comb begin
        bsel = {cnt_q, 3'b000};
        raw  = lbuf_q;
        raw[bsel +: 8] = ram_rdata;
        case (op_q)
            OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:  ext = {24'h000000, raw[7:0]};
            OP_LHU:  ext = {16'h0000, raw[15:0]};
            default: ext = raw;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        op_d       = op_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        lbuf_d     = lbuf_q;
        waddr_d    = waddr_q;
        we_d       = we_q;
        wb_waddr_d = wb_waddr;
        wb_we_d    = wb_we;
        wb_wdata_d = wb_wdata;
        ram_req    = 1'b0;
        ram_rw     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        stall_req  = 1'b0;

        case (state_q)
            IDLE: begin
                wb_we_d = 1'b0;
                if (mem_valid) begin
                    if (in_ls) begin
                        op_d      = mem_op;
                        addr_d    = mem_addr;
                        sdata_d   = mem_sdata;
                        waddr_d   = mem_waddr;
                        we_d      = mem_we;
                        last_d    = in_last;
                        cnt_d     = '0;
                        lbuf_d    = '0;
                        state_d   = XFER;
                        stall_req = 1'b1;
                    end else begin
                        wb_waddr_d = mem_waddr;
                        wb_we_d    = mem_we;
                        wb_wdata_d = mem_wdata;
                    end
                end
            end
            XFER: begin
                ram_req   = 1'b1;
                ram_rw    = store_q;
                ram_addr  = addr_q + XW'(cnt_q);
                ram_wdata = sdata_q[bsel +: 8];
                stall_req = 1'b1;
                if (ram_ack) begin
                    if (cnt_q != last_q) begin
                        if (!store_q) lbuf_d = raw;
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        state_d = DONE;
                        if (store_q) begin
                            wb_we_d = 1'b0;
                        end else begin
                            wb_waddr_d = waddr_q;
                            wb_we_d    = we_q;
                            wb_wdata_d = ext;
                        end
                    end
                end
            end
            DONE: begin
                wb_we_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Stall must drop the instant reset asserts, even with a request on the inputs.
        if (!rst) stall_req = 1'b0;
    end

    // State and write-back registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            lbuf_q   <= '0;
            waddr_q  <= '0;
            we_q     <= 1'b0;
            wb_waddr <= '0;
            wb_we    <= 1'b0;
            wb_wdata <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            lbuf_q   <= lbuf_d;
            waddr_q  <= waddr_d;
            we_q     <= we_d;
            wb_waddr <= wb_waddr_d;
            wb_we    <= wb_we_d;
            wb_wdata <= wb_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a RAM responder checks byte transfers, a write-back
// monitor checks results, both against queues filled when each instruction is issued.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_op;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        ram_req;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        ram_ack;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        stall_req;

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_op    (mem_op),
        .mem_waddr (mem_waddr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_sdata (mem_sdata),
        .ram_req   (ram_req),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .wb_waddr  (wb_waddr),
        .wb_we     (wb_we),
        .wb_wdata  (wb_wdata),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } xfer_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;

    xfer_t       xq[$];
    wb_t         wq[$];
    logic [7:0]  rdq[$];

    int          checks = 0;
    int          errors = 0;
    int          ram_delay = 0;
    int          wait_cnt = 0;
    int          ack_count = 0;
    logic        hold_valid = 1'b0;
    logic [31:0] hold_addr;
    logic        hold_rw;
    logic [7:0]  hold_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM responder: acks after ram_delay wait cycles, checks each accepted byte.
    always @(negedge clk) begin : ram_model
        xfer_t e;
        if (rst && ram_req) begin
            if (hold_valid) begin
                chk("ram_addr_stable", ram_addr, hold_addr);
                chk("ram_rw_stable", 32'(ram_rw), 32'(hold_rw));
                chk("ram_wdata_stable", 32'(ram_wdata), 32'(hold_wdata));
            end
            if (wait_cnt < ram_delay) begin
                ram_ack    = 1'b0;
                wait_cnt++;
                hold_valid = 1'b1;
                hold_addr  = ram_addr;
                hold_rw    = ram_rw;
                hold_wdata = ram_wdata;
            end else begin
                ram_ack    = 1'b1;
                wait_cnt   = 0;
                hold_valid = 1'b0;
                ack_count++;
                if (xq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ram_xfer: addr=0x%08h rw=%0d expected none", ram_addr, ram_rw);
                end else begin
                    e = xq.pop_front();
                    chk("ram_addr", ram_addr, e.addr);
                    chk("ram_rw", 32'(ram_rw), 32'(e.rw));
                    if (e.rw) chk("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
                end
                ram_rdata = (rdq.size() != 0) ? rdq.pop_front() : 8'h00;
            end
        end else begin
            ram_ack    = 1'b0;
            wait_cnt   = 0;
            hold_valid = 1'b0;
        end
    end

    // Write-back monitor: every wb_we pulse must match the next expected result.
    always @(negedge clk) begin : wb_mon
        wb_t w;
        if (wb_we === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb_write: waddr=%0d wdata=0x%08h expected none", wb_waddr, wb_wdata);
            end else begin
                w = wq.pop_front();
                chk("wb_waddr", 32'(wb_waddr), 32'(w.waddr));
                chk("wb_wdata", wb_wdata, w.wdata);
            end
        end
    end

    // Issue one instruction at posedge+1 and hold it while stall_req is high.
    task automatic issue(input logic [3:0] op, input logic [4:0] wa, input logic we,
                         input logic [31:0] wd, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdw, input logic exp_wb, input logic [31:0] exp_wd,
                         input int exp_stall, input string name);
        int   nb;
        int   n;
        int   guard;
        logic st;
        case (op)
            4'd1, 4'd4, 4'd6: nb = 1;
            4'd2, 4'd5, 4'd7: nb = 2;
            4'd3, 4'd8:       nb = 4;
            default:          nb = 0;
        endcase
        st = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
        for (int i = 0; i < nb; i++) begin
            xq.push_back('{st, addr + 32'(i), sd[8*i +: 8]});
            if (!st) rdq.push_back(rdw[8*i +: 8]);
        end
        if (exp_wb) wq.push_back('{wa, exp_wd});
        mem_valid = 1'b1;
        mem_op    = op;
        mem_waddr = wa;
        mem_we    = we;
        mem_wdata = wd;
        mem_addr  = addr;
        mem_sdata = sd;
        #1;
        n     = 0;
        guard = 0;
        do begin
            if (stall_req) n++;
            @(posedge clk);
            #1;
            guard++;
        end while (stall_req && guard < 500);
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: stall_req still high after %0d cycles, required release", name, guard);
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : stim
        int guard;
        int base;
        rst       = 1'b0;
        mem_valid = 1'b0;
        mem_op    = 4'd0;
        mem_waddr = 5'd0;
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
        mem_addr  = 32'd0;
        mem_sdata = 32'd0;
        ram_rdata = 8'd0;
        ram_ack   = 1'b0;
        #1;
        chk("reset_wb_we", 32'(wb_we), 32'd0);
        chk("reset_wb_waddr", 32'(wb_waddr), 32'd0);
        chk("reset_wb_wdata", wb_wdata, 32'd0);
        chk("reset_ram_req", 32'(ram_req), 32'd0);
        chk("reset_stall_req", 32'(stall_req), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd0,  5'd5,  1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, 32'h12345678, 0, "nop");
        issue(4'd3,  5'd7,  1'b1, 32'h0, 32'h00000100, 32'h0, 32'h12345678, 1'b1, 32'h12345678, 5, "lw");
        issue(4'd1,  5'd8,  1'b1, 32'h0, 32'h00000201, 32'h0, 32'h00000080, 1'b1, 32'hFFFFFF80, 2, "lb");
        issue(4'd4,  5'd9,  1'b1, 32'h0, 32'h00000201, 32'h0, 32'h00000080, 1'b1, 32'h00000080, 2, "lbu");
        issue(4'd2,  5'd10, 1'b1, 32'h0, 32'h00000202, 32'h0, 32'h00008000, 1'b1, 32'hFFFF8000, 3, "lh");
        issue(4'd5,  5'd11, 1'b1, 32'h0, 32'h00000401, 32'h0, 32'h00009234, 1'b1, 32'h00009234, 3, "lhu");
        issue(4'd7,  5'd12, 1'b1, 32'h0, 32'h00000300, 32'hAABBCCDD, 32'h0, 1'b0, 32'h0, 3, "sh");
        issue(4'd8,  5'd13, 1'b1, 32'h0, 32'h00000303, 32'h01020304, 32'h0, 1'b0, 32'h0, 5, "sw");
        issue(4'd3,  5'd14, 1'b0, 32'h0, 32'h00000010, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 5, "lw_nowe");
        issue(4'd12, 5'd3,  1'b1, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA5A5A5A5, 0, "op12");

        // Invalid slot: write enable drops, address and data hold.
        mem_valid = 1'b0;
        mem_op    = 4'd0;
        mem_we    = 1'b1;
        mem_waddr = 5'd31;
        mem_wdata = 32'hFFFFFFFF;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("idle_wb_we", 32'(wb_we), 32'd0);
        chk("idle_wb_waddr", 32'(wb_waddr), 32'd3);
        chk("idle_wb_wdata", wb_wdata, 32'hA5A5A5A5);

        ram_delay = 3;
        issue(4'd3, 5'd15, 1'b1, 32'h0, 32'h00000500, 32'h0, 32'h44332211, 1'b1, 32'h44332211, 17, "lw_slow");
        ram_delay = 0;

        // Reset after two acks of a wrapping LW: everything clears at once, no write-back.
        base = ack_count;
        xq.push_back('{1'b0, 32'hFFFFFFFE, 8'h00});
        xq.push_back('{1'b0, 32'hFFFFFFFF, 8'h00});
        rdq.push_back(8'h01);
        rdq.push_back(8'h02);
        mem_valid = 1'b1;
        mem_op    = 4'd3;
        mem_waddr = 5'd20;
        mem_we    = 1'b1;
        mem_addr  = 32'hFFFFFFFE;
        mem_sdata = 32'h55667788;
        guard = 0;
        while (ack_count < base + 2 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL abort_wait: acks=%0d required %0d", ack_count - base, 2);
        end
        #1;
        rst = 1'b0;
        #1;
        chk("abort_ram_req", 32'(ram_req), 32'd0);
        chk("abort_ram_rw", 32'(ram_rw), 32'd0);
        chk("abort_ram_addr", ram_addr, 32'd0);
        chk("abort_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("abort_wb_we", 32'(wb_we), 32'd0);
        chk("abort_wb_waddr", 32'(wb_waddr), 32'd0);
        chk("abort_wb_wdata", wb_wdata, 32'd0);
        chk("abort_stall_req", 32'(stall_req), 32'd0);
        xq.delete();
        rdq.delete();
        mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd0, 5'd6,  1'b1, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D, 0, "nop_after_reset");
        issue(4'd3, 5'd21, 1'b1, 32'h0, 32'hFFFFFFFE, 32'h0, 32'hCAFEBABE, 1'b1, 32'hCAFEBABE, 5, "lw_wrap");

        repeat (2) @(posedge clk);
        #1;
        chk("xfer_queue_drained", 32'(xq.size()), 32'd0);
        chk("wb_queue_drained", 32'(wq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; one clock, reset asynchronous and active-low (rst=0 resets).
REQ-003 SHALL have ports: mem_valid in 1 instruction present; mem_op in 4 access type; mem_waddr in 5 dest reg; mem_we in 1 reg write enable; mem_wdata in 32 ALU result.
REQ-004 SHALL have ports: mem_addr in 32 effective address; mem_sdata in 32 store data.
REQ-005 SHALL have ports: ram_req out 1 byte request; ram_rw out 1 (1=write); ram_addr out 32 byte address; ram_wdata out 8 store byte; ram_rdata in 8 load byte; ram_ack in 1 byte accepted/returned this cycle.
REQ-006 SHALL have ports: wb_waddr out 5; wb_we out 1; wb_wdata out 32 (registered, to write-back); stall_req out 1 (upstream holds mem_* stable while 1).

Function
REQ-007 mem_op encoding SHALL be: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 SHALL behave as NOP.
REQ-008 FSM SHALL have states IDLE, XFER, DONE.
REQ-009 IDLE, mem_valid=1, NOP: next edge wb_waddr/wb_we/wb_wdata <= mem_waddr/mem_we/mem_wdata; stay IDLE.
REQ-010 IDLE, mem_valid=0: next edge wb_we <= 0; wb_waddr, wb_wdata unchanged.
REQ-011 IDLE, mem_valid=1, load/store: next edge latch op, addr, sdata, waddr, we; byte count n (1 B, 2 H, 4 W); cnt <= 0; state <= XFER; wb_we <= 0.
REQ-012 XFER: ram_req=1, ram_rw=1 for stores else 0, ram_addr=addr_latched+cnt (32-bit wrap), ram_wdata=sdata_latched[8*cnt+7:8*cnt]; all combinational from registered state.
REQ-013 XFER, ram_ack=0: no state change; ram_req, ram_addr, ram_rw, ram_wdata SHALL stay stable; wait unbounded (no timeout).
REQ-014 XFER, ram_ack=1 and cnt<n-1: loads capture ram_rdata into byte cnt of load buffer; cnt <= cnt+1.
REQ-015 XFER, ram_ack=1 and cnt=n-1: state <= DONE; loads: wb_waddr <= waddr_latched, wb_we <= we_latched, wb_wdata <= assembled value incl. final ram_rdata byte; stores: wb_we <= 0.
REQ-016 Byte order little-endian: byte cnt holds bits [8*cnt+7:8*cnt]; no alignment check; misaligned accesses complete byte-serially.
REQ-017 Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unmodified.
REQ-018 DONE: inputs ignored; next edge wb_we <= 0, state <= IDLE.
REQ-019 stall_req SHALL be combinational: 1 when (IDLE and mem_valid and load/store op) or XFER; 0 in DONE and otherwise.
REQ-020 Latency, zero-wait RAM: LW = accept cycle + 4 XFER cycles, result on wb_* in DONE cycle; stall_req high 5 cycles; LB 2 cycles; NOP 1-cycle registered pass-through.
REQ-021 ram_req SHALL be 0 outside XFER; ram_ack outside XFER SHALL be ignored.
REQ-022 Inputs in XFER/DONE SHALL be ignored (latched copies used).

Reset
REQ-023 rst=0 SHALL immediately (no clock edge) force state IDLE, cnt 0, latches 0, wb_waddr 0, wb_we 0, wb_wdata 0, ram_req 0, ram_rw 0, ram_addr 0, ram_wdata 0, stall_req 0.
REQ-024 Reset mid-access SHALL abandon the access without wb write; after release the next op starts from IDLE.

Verification
REQ-025 NOP: valid=1, op=0, waddr=5, we=1, wdata=0x12345678 -> next edge wb_waddr=5, wb_we=1, wb_wdata=0x12345678, stall_req=0.
REQ-026 LW addr 0x100, bytes 78,56,34,12, ack every cycle -> ram_addr 0x100..0x103, stall_req high 5 cycles, wb_wdata=0x12345678, wb_we=1 one cycle.
REQ-027 LB addr 0x201 byte 0x80 -> wb_wdata=0xFFFFFF80; LBU same -> 0x00000080; LH bytes 00,80 -> 0xFFFF8000.
REQ-028 SH addr 0x300, sdata 0xAABBCCDD -> ram_rw=1, ram_wdata 0xDD at 0x300 then 0xCC at 0x301, wb_we stays 0.
REQ-029 LW, ack delayed 3 cycles per byte -> ram_req/ram_addr stable while waiting, stall_req held, result correct after 4 acks.
REQ-030 LW addr 0xFFFFFFFE, rst=0 after 2 acks -> all outputs 0 at once, no wb write; after release NOP pass-through works; separate LW at 0xFFFFFFFE wraps ram_addr to 0x00000000, 0x00000001.
